// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stall/flush enables, memory-wait freeze with timeout trap, EX forwarding.
// Optional performance counters (o_stall_cnt, o_flush_cnt) are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_ex_rs,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_memread,
  input  logic        i_mem_regwrite,
  input  logic        i_wb_regwrite,
  input  logic [4:0]  i_mem_rd,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_mem_branch_taken,
  input  logic        i_mem_access,
  input  logic        i_dmem_ready,
  output logic        o_pc_en,
  output logic        o_ifid_en,
  output logic        o_idex_en,
  output logic        o_exmem_en,
  output logic        o_memwb_en,
  output logic        o_ifid_flush,
  output logic        o_idex_flush,
  output logic        o_exmem_flush,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b,
`ifdef HAZARD_PERF_EN
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`else
  output logic        o_mem_timeout
`endif
);

  typedef enum logic [1:0] {S_RUN, S_MWAIT, S_TOUT} state_t;

  localparam logic [15:0] LP_TIMEOUT = MEM_TIMEOUT[15:0];

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_next_wait_cnt;
  logic        r_mem_timeout;
  logic        w_freeze;
  logic        w_loaduse;
  logic        w_branch_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_wait_cnt    <= w_next_wait_cnt;
      r_mem_timeout <= (w_next_state == S_TOUT);
    end
  end

  // wait_cnt holds the number of not-ready cycles already seen in this wait
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      S_RUN: begin
        if (i_mem_access && !i_dmem_ready) begin
          w_next_state    = S_MWAIT;
          w_next_wait_cnt = 16'd1;
        end
      end
      S_MWAIT: begin
        if (i_dmem_ready) begin
          w_next_state    = S_RUN;
          w_next_wait_cnt = 16'd0;
        end else if (r_wait_cnt == LP_TIMEOUT) begin
          w_next_state = S_TOUT;
        end else begin
          w_next_wait_cnt = r_wait_cnt + 16'd1;
        end
      end
      S_TOUT: begin
        w_next_state = S_TOUT;
      end
      default: begin
        w_next_state    = S_RUN;
        w_next_wait_cnt = 16'd0;
      end
    endcase
  end

  assign w_freeze  = (r_state == S_TOUT) || (i_mem_access && !i_dmem_ready);
  assign w_loaduse = i_ex_memread && (i_ex_rt != 5'd0) &&
                     ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
  assign w_branch_sel = i_rst_n && !w_freeze && i_mem_branch_taken;

  // Freeze defers branch and load-use: their sources sit in the frozen registers
  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_idex_en     = 1'b1;
    o_exmem_en    = 1'b1;
    o_memwb_en    = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    if (!i_rst_n) begin
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_idex_en     = 1'b0;
      o_exmem_en    = 1'b0;
      o_memwb_en    = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (w_freeze) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_en  = 1'b0;
      o_exmem_en = 1'b0;
      o_memwb_en = 1'b0;
    end else if (i_mem_branch_taken) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (w_loaduse) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end
  end

  always_comb begin
    o_fwd_a = 2'b00;
    o_fwd_b = 2'b00;
    if (i_rst_n) begin
      if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs))
        o_fwd_a = 2'b10;
      else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rs))
        o_fwd_a = 2'b01;
      if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rt))
        o_fwd_b = 2'b10;
      else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rt))
        o_fwd_b = 2'b01;
    end
  end

  assign o_mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!o_pc_en && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_branch_sel && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  logic w_unused_branch_sel;
  assign w_unused_branch_sel = w_branch_sel;
`endif

endmodule
